fir_mac_engine: RTL and testbench
=================================

// Module: fir_mac_engine
// PURPOSE
//   Parametrised, handshaked multiply-accumulate engine for the FIR datapath; successor to the fixed 64-tap MAC.
//   Accepts one signed (x, coeff) pair per accepted beat and accumulates a frame of TAPS products.
//   Presents the scaled, rounded and optionally saturated sum on a valid/ready output, plus a one-cycle tick.
//   Upstream: tap/coefficient sequencer. Downstream: output sample buffer.
// PARAMETERS
//   DATA_W  16  signed sample width
//   COEF_W  16  signed coefficient width
//   TAPS    64  products per frame (>=2)
//   OUT_W   32  signed result width
//   SHIFT    0  right shift applied to the accumulator before output (0..ACC_W-1)
//   SAT_EN   1  1: saturate to OUT_W; 0: wrap (keep low OUT_W bits)
//   (local) ACC_W = DATA_W+COEF_W+$clog2(TAPS); the accumulator can never overflow
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   clear      in   1        synchronous frame abort
//   in_valid   in   1        x/coeff valid
//   in_ready   out  1        engine accepts a pair this cycle
//   x          in   DATA_W   signed sample
//   coeff      in   COEF_W   signed coefficient
//   out_valid  out  1        y valid, held until accepted
//   out_ready  in   1        downstream accepts y
//   y          out  OUT_W    signed result
//   overflow   out  1        y was clipped (SAT_EN=1) or wrapped (SAT_EN=0); valid with out_valid
//   tick       out  1        one-cycle pulse on the first cycle of each out_valid
//   tap_idx    out  clog2(TAPS)  number of pairs accepted in the current frame
// BEHAVIOUR
//   Reset: state=ACC; acc=0, tap_idx=0, pipeline empty; out_valid=0, y=0, overflow=0, tick=0; in_ready=1.
//   Beat: in_valid & in_ready at a rising edge; no beat means no state change (bubbles allowed).
//   Pipeline: product registered one edge after the beat and added to acc one edge later.
//     All arithmetic is signed two's-complement and sign-extended to ACC_W.
//   States:
//     ACC:   in_ready=1. On a beat, tap_idx++. On the TAPS-th beat (edge E), go to DRAIN and set in_ready=0.
//     DRAIN: in_ready=0; waits for the last product to enter acc.
//            At edge E+2, load y/overflow, set out_valid=1, pulse tick, go to HOLD.
//     HOLD:  in_ready=0; y, overflow and out_valid are stable while out_ready=0.
//            On out_valid & out_ready: out_valid=0, acc=0, tap_idx=0, go to ACC (in_ready=1 the next cycle).
//   Output formatting:
//     r = (acc + (SHIFT ? 1<<(SHIFT-1) : 0)) >>> SHIFT  (round half up).
//     If r lies outside the OUT_W signed range: SAT_EN=1 gives y=+max/-min; SAT_EN=0 gives y=r[OUT_W-1:0].
//     In both cases overflow=1; otherwise overflow=0.
//   clear: overrides everything in any state. Next edge: acc=0, tap_idx=0, pipeline flushed,
//     out_valid=0, tick=0, state=ACC. Any beat presented in the same cycle is dropped.
//   rst mid-frame: immediate return to reset values; the partial frame is discarded.
//   in_valid while in_ready=0: ignored; the inputs need not be held.
//   tick never asserts twice for one result, regardless of how long HOLD lasts.
// TESTING
//   1 TAPS=4; x=1,2,3,4 with coeff=1 on back-to-back beats
//     -> y=10 and out_valid exactly 2 cycles after the 4th beat; tick high for 1 cycle; overflow=0.
//   2 TAPS=64, x=coeff=-32768 on all beats (acc=2^36), OUT_W=32
//     -> SAT_EN=1: y=32'h7FFFFFFF, overflow=1; SAT_EN=0: y=0, overflow=1.
//   3 Hold out_ready=0 for 5 cycles after out_valid with in_valid=1 throughout
//     -> y stable, in_ready=0, tick only on the first cycle.
//     Then handshake: next frame's first beat accepted on the following cycle.
//   4 Random in_valid bubbles over a 64-tap frame of random data
//     -> y equals the contiguous-stream golden model; tap_idx counts beats only.
//   5 SHIFT=1: frame sum 3 -> y=2; frame sum -3 -> y=-1; frame sum 4 -> y=2.
//   6 clear after 10 beats, and rst after 20 beats of another frame
//     -> acc and tap_idx return to 0, no out_valid/tick from the aborted frame; the next full frame is correct.

Source files
------------

// File: rtl/fir_mac_engine.sv
// Handshaked signed multiply-accumulate engine: one (x, coeff) pair per beat, TAPS products per frame,
// scaled/rounded/saturated result presented on a valid/ready output with a first-cycle tick.
module fir_mac_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 64,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned SAT_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  x,
  input  logic signed [COEF_W-1:0]  coeff,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   y,
  output logic                      overflow,
  output logic                      tick,
  output logic [$clog2(TAPS)-1:0]   tap_idx
);

  localparam int unsigned TW    = $clog2(TAPS);
  localparam int unsigned PW    = DATA_W + COEF_W;
  localparam int unsigned ACC_W = PW + TW;
  localparam int unsigned RW    = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;
  localparam logic signed [RW-1:0] RND = (RW'(1) << SHIFT) >> 1;

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_HOLD} state_t;

  state_t                   state_q, state_d;
  logic                     beat, load, done;
  logic                     prod_valid;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [RW-1:0]     r_c;
  logic                     ovf_c;
  logic signed [OUT_W-1:0]  y_c;

  // A beat presented together with clear is dropped.
  assign beat = in_valid & in_ready & ~clear;

  // Next-state and control strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_ACC:   if (beat && tap_idx == TW'(TAPS - 1)) state_d = S_DRAIN;
      S_DRAIN: if (!prod_valid) begin
                 load    = 1'b1;
                 state_d = S_HOLD;
               end
      S_HOLD:  if (out_ready) begin
                 done    = 1'b1;
                 state_d = S_ACC;
               end
      default: state_d = S_ACC;
    endcase
    if (clear) begin
      state_d = S_ACC;
      load    = 1'b0;
      done    = 1'b0;
    end
  end

  // Round half up, then saturate or wrap; overflow when the upper bits are not a pure sign extension.
  always_comb begin
    r_c   = (RW'(acc) + RND) >>> SHIFT;
    ovf_c = !((&r_c[RW-1:OUT_W-1]) || !(|r_c[RW-1:OUT_W-1]));
    y_c   = r_c[OUT_W-1:0];
    if (ovf_c && SAT_EN != 0)
      y_c = r_c[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ACC;
      in_ready   <= 1'b1;
      prod_valid <= 1'b0;
      prod       <= '0;
      acc        <= '0;
      tap_idx    <= '0;
      out_valid  <= 1'b0;
      y          <= '0;
      overflow   <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready   <= (state_d == S_ACC);
      prod_valid <= beat;
      if (beat) prod <= PW'(x) * PW'(coeff);
      if (clear) begin
        acc        <= '0;
        tap_idx    <= '0;
        prod_valid <= 1'b0;
        out_valid  <= 1'b0;
        tick       <= 1'b0;
      end else begin
        tick <= load;
        if (beat) tap_idx <= tap_idx + TW'(1);
        if (prod_valid) acc <= acc + ACC_W'(prod);
        if (load) begin
          y         <= y_c;
          overflow  <= ovf_c;
          out_valid <= 1'b1;
        end
        if (done) begin
          out_valid <= 1'b0;
          acc       <= '0;
          tap_idx   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: four instances (TAPS=4 plain/SHIFT=1, TAPS=64 saturating/wrapping)
// share one stimulus bus; each scenario resets all of them and inspects the instance it targets.
module tb_fir_mac_engine;

  logic clk = 1'b0;
  logic rst, clear, in_valid, out_ready;
  logic signed [15:0] x, coeff;
  int checks = 0;
  int errors = 0;

  logic a_in_ready, a_out_valid, a_overflow, a_tick;
  logic signed [31:0] a_y;
  logic [1:0] a_tap_idx;
  logic b_in_ready, b_out_valid, b_overflow, b_tick;
  logic signed [31:0] b_y;
  logic [1:0] b_tap_idx;
  logic c_in_ready, c_out_valid, c_overflow, c_tick;
  logic signed [31:0] c_y;
  logic [5:0] c_tap_idx;
  logic d_in_ready, d_out_valid, d_overflow, d_tick;
  logic signed [31:0] d_y;
  logic [5:0] d_tap_idx;

  always #5 clk = ~clk;

  fir_mac_engine #(.TAPS(4)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
    .x(x), .coeff(coeff), .out_valid(a_out_valid), .out_ready(out_ready), .y(a_y),
    .overflow(a_overflow), .tick(a_tick), .tap_idx(a_tap_idx));

  fir_mac_engine #(.TAPS(4), .SHIFT(1)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
    .x(x), .coeff(coeff), .out_valid(b_out_valid), .out_ready(out_ready), .y(b_y),
    .overflow(b_overflow), .tick(b_tick), .tap_idx(b_tap_idx));

  fir_mac_engine #(.TAPS(64), .SAT_EN(1)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(c_in_ready),
    .x(x), .coeff(coeff), .out_valid(c_out_valid), .out_ready(out_ready), .y(c_y),
    .overflow(c_overflow), .tick(c_tick), .tap_idx(c_tap_idx));

  fir_mac_engine #(.TAPS(64), .SAT_EN(0)) u_d (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_in_ready),
    .x(x), .coeff(coeff), .out_valid(d_out_valid), .out_ready(out_ready), .y(d_y),
    .overflow(d_overflow), .tick(d_tick), .tap_idx(d_tap_idx));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; coeff = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] xv, input logic signed [15:0] cv);
    in_valid = 1'b1; x = xv; coeff = cv;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_y !== 32'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", a_y); end
    checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", a_overflow); end
    checks++; if (a_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b exp 0", a_tick); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", a_in_ready); end
    checks++; if (a_tap_idx !== 2'd0) begin errors++; $display("FAIL rst_tap_idx got %0d exp 0", a_tap_idx); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    send(16'sd1, 16'sd1);
    send(16'sd2, 16'sd1);
    checks++; if (a_tap_idx !== 2'd2) begin errors++; $display("FAIL t1_tap_idx got %0d exp 2", a_tap_idx); end
    send(16'sd3, 16'sd1);
    send(16'sd4, 16'sd1);
    in_valid = 1'b0;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL t1_in_ready_drain got %b exp 0", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid0 got %b exp 0", a_out_valid); end
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid1 got %b exp 0", a_out_valid); end
    step();
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL t1_out_valid got %b exp 1", a_out_valid); end
    checks++; if (a_y !== 32'sd10) begin errors++; $display("FAIL t1_y got %0d exp 10", a_y); end
    checks++; if (a_tick !== 1'b1) begin errors++; $display("FAIL t1_tick got %b exp 1", a_tick); end
    checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL t1_overflow got %b exp 0", a_overflow); end
    step();
    checks++; if (a_tick !== 1'b0) begin errors++; $display("FAIL t1_tick_after got %b exp 0", a_tick); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_after got %b exp 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL t1_in_ready_after got %b exp 1", a_in_ready); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 64; i++) send(-16'sd32768, -16'sd32768);
    in_valid = 1'b0;
    step();
    step();
    checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL t2_out_valid got %b exp 1", c_out_valid); end
    checks++; if (c_y !== 32'h7FFF_FFFF) begin errors++; $display("FAIL t2_sat_y got %h exp 7fffffff", c_y); end
    checks++; if (c_overflow !== 1'b1) begin errors++; $display("FAIL t2_sat_ovf got %b exp 1", c_overflow); end
    checks++; if (d_y !== 32'h0) begin errors++; $display("FAIL t2_wrap_y got %h exp 0", d_y); end
    checks++; if (d_overflow !== 1'b1) begin errors++; $display("FAIL t2_wrap_ovf got %b exp 1", d_overflow); end
  endtask

  task automatic test_hold();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'sd1, 16'sd2);
    x = 16'sd100;
    step();
    step();
    checks++; if (a_y !== 32'sd8) begin errors++; $display("FAIL t3_y got %0d exp 8", a_y); end
    checks++; if (a_tick !== 1'b1) begin errors++; $display("FAIL t3_tick_first got %b exp 1", a_tick); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (a_y !== 32'sd8) begin errors++; $display("FAIL t3_hold_y[%0d] got %0d exp 8", i, a_y); end
      checks++; if (a_tick !== 1'b0) begin errors++; $display("FAIL t3_hold_tick[%0d] got %b exp 0", i, a_tick); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL t3_hold_in_ready[%0d] got %b exp 0", i, a_in_ready); end
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL t3_hold_valid[%0d] got %b exp 1", i, a_out_valid); end
    end
    out_ready = 1'b1; x = 16'sd3; coeff = 16'sd1;
    step();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL t3_rearm got %b exp 1", a_in_ready); end
    checks++; if (a_tap_idx !== 2'd0) begin errors++; $display("FAIL t3_tap_clr got %0d exp 0", a_tap_idx); end
    step();
    checks++; if (a_tap_idx !== 2'd1) begin errors++; $display("FAIL t3_first_beat got %0d exp 1", a_tap_idx); end
    for (int i = 0; i < 3; i++) send(16'sd3, 16'sd1);
    in_valid = 1'b0;
    step();
    step();
    checks++; if (a_y !== 32'sd12) begin errors++; $display("FAIL t3_next_y got %0d exp 12", a_y); end
  endtask

  task automatic test_bubbles();
    logic signed [7:0] t;
    longint sum;
    int nb;
    do_reset();
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      nb = 0;
      while ($urandom_range(0, 2) == 0 && nb < 4) begin
        in_valid = 1'b0; x = 16'($urandom); nb++;
        step();
      end
      t = 8'($urandom);
      x = 16'(t);
      t = 8'($urandom);
      coeff = 16'(t);
      sum += longint'(x) * longint'(coeff);
      in_valid = 1'b1;
      step();
      if (i < 63) begin
        checks++;
        if (c_tap_idx !== 6'(i + 1)) begin errors++; $display("FAIL t4_tap_idx[%0d] got %0d exp %0d", i, c_tap_idx, i + 1); end
      end
    end
    in_valid = 1'b0;
    step();
    step();
    checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL t4_out_valid got %b exp 1", c_out_valid); end
    checks++; if (c_y !== 32'(sum)) begin errors++; $display("FAIL t4_y got %0d exp %0d", c_y, sum); end
    checks++; if (c_overflow !== 1'b0) begin errors++; $display("FAIL t4_overflow got %b exp 0", c_overflow); end
  endtask

  task automatic test_shift_round();
    do_reset();
    send(16'sd1, 16'sd1); send(16'sd1, 16'sd1); send(16'sd1, 16'sd1); send(16'sd0, 16'sd1);
    in_valid = 1'b0; step(); step();
    checks++; if (b_y !== 32'sd2) begin errors++; $display("FAIL t5_pos3 got %0d exp 2", b_y); end
    step();
    send(-16'sd1, 16'sd1); send(-16'sd1, 16'sd1); send(-16'sd1, 16'sd1); send(16'sd0, 16'sd1);
    in_valid = 1'b0; step(); step();
    checks++; if (b_y !== -32'sd1) begin errors++; $display("FAIL t5_neg3 got %0d exp -1", b_y); end
    step();
    for (int i = 0; i < 4; i++) send(16'sd1, 16'sd1);
    in_valid = 1'b0; step(); step();
    checks++; if (b_y !== 32'sd2) begin errors++; $display("FAIL t5_pos4 got %0d exp 2", b_y); end
    checks++; if (b_tick !== 1'b1) begin errors++; $display("FAIL t5_tick got %b exp 1", b_tick); end
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 10; i++) send(16'sd1, 16'sd1);
    clear = 1'b1; x = 16'sd50;
    step();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (c_tap_idx !== 6'd0) begin errors++; $display("FAIL t6_clear_tap got %0d exp 0", c_tap_idx); end
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL t6_clear_ready got %b exp 1", c_in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (c_out_valid !== 1'b0 || c_tick !== 1'b0) begin
        errors++; $display("FAIL t6_clear_quiet[%0d] got valid=%b tick=%b exp 0 0", i, c_out_valid, c_tick);
      end
    end
    for (int i = 0; i < 20; i++) send(16'sd2, 16'sd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++; if (c_tap_idx !== 6'd0) begin errors++; $display("FAIL t6_rst_tap got %0d exp 0", c_tap_idx); end
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_valid got %b exp 0", c_out_valid); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) send(16'sd1, 16'sd3);
    in_valid = 1'b0;
    step();
    step();
    checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL t6_next_valid got %b exp 1", c_out_valid); end
    checks++; if (c_y !== 32'sd192) begin errors++; $display("FAIL t6_next_y got %0d exp 192", c_y); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_saturation();
    test_hold();
    test_bubbles();
    test_shift_round();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
